tinker_fetch_unit: RTL and testbench

//  Decoupled instruction-fetch stage feeding the Tinker decoder. Issues in-order 32-bit reads to

---
 rtl/tinker_fetch_pkg.sv | 20 ++
 rtl/tinker_fetch_fifo.sv | 80 ++++++++
 rtl/tinker_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_tinker_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_fetch_pkg.sv
// Shared types and constants for the Tinker instruction-fetch stage.
//   fetch_state_e : FETCH (issuing requests) / FLUSH (draining stale responses)
//   fetch_entry_t : one buffered instruction word together with its PC
package tinker_fetch_pkg;

  localparam int          INST_W          = 32;
  localparam int          ADDR_W          = 64;
  localparam logic [63:0] TINKER_RESET_PC = 64'h2000;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/tinker_fetch_fifo.sv
// First-word-fall-through FIFO of fetch entries.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data this cycle (caller guarantees not full)
//   push_data  : entry to write
//   pop        : retire the head entry this cycle (caller guarantees not empty)
//   flush      : empty the FIFO; overrides same-cycle push and pop
//   full/empty : occupancy flags
//   count      : number of entries held
//   head       : entry at the head; meaningful only while !empty
module tinker_fetch_fifo
  import tinker_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tinker_fetch_unit.sv
// Decoupled instruction-fetch stage.
// Issues in-order word reads to instruction memory, buffers returned words with
// their PCs, and hands them to decode. A redirect flushes buffered words and
// marks every in-flight request as stale so its response is discarded.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   imem_req_*       : request port (valid/ready) carrying a word-aligned address
//   imem_resp_*      : in-order, unstallable response data
//   redirect_*       : one-cycle pulse with the new PC (bits [1:0] ignored)
//   inst_*           : instruction + PC to decode (valid/ready)
// Handshake rule for both valid/ready ports: a transfer happens on a rising edge
// where valid and ready are both high; once valid rises, valid and the payload
// stay unchanged until that transfer (a redirect may withdraw a fetch request).
module tinker_fetch_unit
  import tinker_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = TINKER_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [63:0] inst_pc
);

  localparam int             CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] CAP   = (CNT_W + 1)'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [63:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             req_valid_q, req_valid_d;

  logic             req_fire;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W-1:0] count_next;
  logic [63:0]      redirect_pc_aligned;
  logic             redirect_pc_unused;

  logic             fifo_push, fifo_pop, fifo_flush;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head, push_entry;

  assign req_fire            = req_valid_q & imem_req_ready;
  assign fifo_pop            = ~fifo_empty & inst_ready;
  assign redirect_pc_aligned = {redirect_pc[63:2], 2'b00};
  assign redirect_pc_unused  = |redirect_pc[1:0];
  // Requests accepted but not yet answered after this cycle's events.
  assign in_flight           = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = in_flight;
    drop_cnt_d    = drop_cnt_q;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    push_entry    = '{pc: resp_pc_q, word: imem_resp_data};
    count_next    = fifo_count;

    if (redirect_valid) begin
      // Everything still in flight, including a request accepted this very
      // cycle, belongs to the old stream and must be thrown away on return.
      fifo_flush = 1'b1;
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      drop_cnt_d = in_flight;
      state_d    = (in_flight != '0) ? FLUSH : FETCH;
      count_next = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (imem_resp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end else begin
          fifo_push = 1'b1;
          resp_pc_d = resp_pc_q + 64'd4;
        end
      end
      if (state_q == FLUSH && drop_cnt_d == '0) begin
        state_d = FETCH;
      end
      count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    // Credit check uses next-cycle occupancy so the request valid can be a flop.
    req_valid_d = (state_d == FETCH) &&
                  (({1'b0, outstanding_d} + {1'b0, count_next}) < CAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      req_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      req_valid_q   <= req_valid_d;
    end
  end

  tinker_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = ~fifo_empty;
  assign inst_word      = fifo_empty ? '0 : fifo_head.word;
  assign inst_pc        = fifo_empty ? '0 : fifo_head.pc;

  resp_has_request_a: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (outstanding_q != '0));
  no_push_when_full_a: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push && fifo_full && !fifo_flush));

endmodule

// File: tb/tb_tinker_fetch_unit.sv
module tb_tinker_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tinker_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_word       (inst_word),
    .inst_pc         (inst_pc)
  );

  // ---------------- bench state ----------------
  typedef struct {
    int          tag;
    logic [63:0] addr;
  } mem_req_t;

  mem_req_t    pending[$];   // accepted requests awaiting a response
  logic [95:0] exp_q[$];     // {pc, word} expected at decode, in order
  logic [63:0] hs_addrs[$];  // observed accepted request addresses
  logic [63:0] del_pcs[$];   // observed PCs consumed by decode
  int          epoch = 0;
  int          hs_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_addr = 64'h2000;
  bit          req_ready_en = 1'b1;
  bit          resp_en = 1'b1;
  bit          inst_ready_en = 1'b1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one cycle ----------------
  // Observes outputs at the falling edge, scores them, then drives inputs for
  // the next rising edge (memory responder, request ready, decode ready, redirect).
  task automatic step(input bit redir = 1'b0, input logic [63:0] rpc = 64'h0);
    int          stale;
    int          old_epoch;
    bit          hs;
    mem_req_t    r;
    logic [31:0] w;
    @(negedge clk);
    stale = 0;
    foreach (pending[i]) if (pending[i].tag != epoch) stale++;
    chk("req_valid", 96'(imem_req_valid),
        96'((stale == 0) && ((pending.size() + exp_q.size()) < 4)));
    if (imem_req_valid) chk("req_addr", 96'(imem_req_addr), 96'(exp_addr));
    chk("inst_valid", 96'(inst_valid), 96'(exp_q.size() != 0));
    if (inst_valid && exp_q.size() != 0) begin
      chk("inst_pc", 96'(inst_pc), 96'(exp_q[0][95:32]));
      chk("inst_word", 96'(inst_word), 96'(exp_q[0][31:0]));
      if (inst_ready_en && !redir) begin
        del_pcs.push_back(inst_pc);
        void'(exp_q.pop_front());
      end
    end

    old_epoch = epoch;
    if (redir) begin
      epoch++;
      exp_q.delete();
    end

    if (resp_en && pending.size() != 0) begin
      r = pending.pop_front();
      w = mem_word(r.addr);
      imem_resp_valid = 1'b1;
      imem_resp_data  = w;
      if (r.tag == epoch) exp_q.push_back({r.addr, w});
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end

    imem_req_ready = req_ready_en;
    hs = imem_req_valid && req_ready_en;
    if (hs) begin
      pending.push_back('{old_epoch, exp_addr});
      hs_addrs.push_back(imem_req_addr);
      hs_cnt++;
    end
    if (redir) exp_addr = {rpc[63:2], 2'b00};
    else if (hs) exp_addr = exp_addr + 64'd4;

    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = inst_ready_en;
  endtask

  // Asserts reset between clock edges and checks outputs respond immediately.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset           = 1'b1;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b0;
    inst_ready      = 1'b0;
    #1;
    chk("rst_req_valid", 96'(imem_req_valid), 96'(0));
    chk("rst_req_addr", 96'(imem_req_addr), 96'(64'h2000));
    chk("rst_inst_valid", 96'(inst_valid), 96'(0));
    chk("rst_inst_word", 96'(inst_word), 96'(0));
    chk("rst_inst_pc", 96'(inst_pc), 96'(0));
    pending.delete();
    exp_q.delete();
    hs_addrs.delete();
    del_pcs.delete();
    hs_cnt   = 0;
    exp_addr = 64'h2000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int vcnt;
    #1 reset = 1'b1;

    // 1: streaming, addresses and PCs from 0x2000, one instruction per cycle
    apply_reset();
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i >= 6 && i < 26 && inst_valid) vcnt++;
    end
    chk("t1_throughput", 96'(vcnt), 96'(20));
    chk("t1_addr0", 96'(hs_addrs[0]), 96'(64'h2000));
    chk("t1_addr1", 96'(hs_addrs[1]), 96'(64'h2004));
    chk("t1_addr2", 96'(hs_addrs[2]), 96'(64'h2008));
    chk("t1_pc0", 96'(del_pcs[0]), 96'(64'h2000));
    chk("t1_pc1", 96'(del_pcs[1]), 96'(64'h2004));

    // 2: decode stalled -> credit cap of 4, then resume
    apply_reset();
    inst_ready_en = 1'b0;
    repeat (12) step();
    chk("t2_req_count", 96'(hs_cnt), 96'(4));
    chk("t2_req_valid_low", 96'(imem_req_valid), 96'(0));
    inst_ready_en = 1'b1;
    repeat (10) step();
    chk("t2_resumed", 96'(hs_cnt > 4), 96'(1));

    // 3: redirect to 0x3002 with one word buffered and 3 requests in flight
    apply_reset();
    inst_ready_en = 1'b0;
    for (int i = 0; i < 10 && hs_cnt < 1; i++) step();
    req_ready_en = 1'b0;
    repeat (3) step();
    resp_en      = 1'b0;
    req_ready_en = 1'b1;
    for (int i = 0; i < 10 && hs_cnt < 4; i++) step();
    req_ready_en = 1'b0;
    chk("t3_in_flight", 96'(pending.size()), 96'(3));
    hs_addrs.delete();
    del_pcs.delete();
    step(1'b1, 64'h3002);
    resp_en       = 1'b1;
    req_ready_en  = 1'b1;
    inst_ready_en = 1'b1;
    step();
    chk("t3_fifo_empty", 96'(inst_valid), 96'(0));
    repeat (12) step();
    chk("t3_first_addr", 96'(hs_addrs[0]), 96'(64'h3000));
    chk("t3_first_pc", 96'(del_pcs[0]), 96'(64'h3000));

    // 4: redirect coinciding with a response and a request handshake
    repeat (4) step();
    step(1'b1, 64'h6000);
    hs_addrs.delete();
    del_pcs.delete();
    repeat (10) step();
    chk("t4_first_addr", 96'(hs_addrs[0]), 96'(64'h6000));
    chk("t4_first_pc", 96'(del_pcs[0]), 96'(64'h6000));

    // 5: back-to-back redirects, second one during the flush
    repeat (4) step();
    resp_en = 1'b0;
    step(1'b1, 64'h4000);
    hs_addrs.delete();
    del_pcs.delete();
    step(1'b1, 64'h5000);
    resp_en = 1'b1;
    repeat (15) step();
    chk("t5_first_addr", 96'(hs_addrs[0]), 96'(64'h5000));
    for (int i = 0; i < 4; i++)
      chk("t5_pc_stream", 96'(del_pcs[i]), 96'(64'h5000 + 64'(4 * i)));

    // 6: reset with buffered words and 2 requests in flight
    apply_reset();
    inst_ready_en = 1'b0;
    for (int i = 0; i < 10 && hs_cnt < 2; i++) step();
    req_ready_en = 1'b0;
    repeat (3) step();
    resp_en      = 1'b0;
    req_ready_en = 1'b1;
    for (int i = 0; i < 10 && hs_cnt < 4; i++) step();
    req_ready_en = 1'b0;
    step();
    chk("t6_in_flight", 96'(pending.size()), 96'(2));
    apply_reset();
    inst_ready_en = 1'b1;
    resp_en       = 1'b1;
    req_ready_en  = 1'b1;
    repeat (6) step();
    chk("t6_first_addr", 96'(hs_addrs[0]), 96'(64'h2000));
    chk("t6_first_pc", 96'(del_pcs[0]), 96'(64'h2000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
